seq_capture_checker: RTL and testbench
======================================

Name: seq_capture_checker

Overview:
- Downstream consumer of the 8-bit sampled data stream that the clocking-block sampling stage produces. That stage captures an incrementing counter value each active clock edge.
- This block runs in the single consuming clock domain. It checks that successive samples advance by a fixed step (modulo 2^WIDTH) and tags every sample with a pass/fail flag.
- Tagged samples are buffered in a small FIFO for a valid/ready consumer (scoreboard or monitor).
- Error and overflow statistics are exposed as status outputs.

Parameters:
- WIDTH, 8, data width of the sampled value.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- STEP, 1, expected increment between consecutive samples, modulo 2^WIDTH.
- CNT_W, 16, width of the error and drop counters.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present this cycle.
- in_data  input  WIDTH  sampled value.
- out_valid  output  1  FIFO non-empty; head entry presented.
- out_ready  input  1  consumer accepts head this cycle.
- out_data  output  WIDTH  head sample value.
- out_err  output  1  head sample broke the sequence.
- locked  output  1  checker has a reference value.
- err_count  output  CNT_W  saturating count of sequence breaks.
- drop_count  output  CNT_W  saturating count of samples dropped on a full FIFO.
- overflow  output  1  sticky; set on the first drop, cleared only by rst.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Nothing is sampled asynchronously.
- Reset values:
  - out_valid=0, locked=0, err_count=0, drop_count=0, overflow=0.
  - out_data and out_err are 0. Both are don't-care while out_valid=0.
  - FIFO is emptied and the FSM goes to UNLOCKED.
- Reset mid-operation discards all buffered entries in the same cycle; no partial pop completes.
- FSM states:
  - UNLOCKED: the first accepted sample loads expected = in_data+STEP. The sample is pushed with err=0 and the state goes to LOCKED.
  - LOCKED: each accepted sample compares in_data with expected.
    - Match: push with err=0 and set expected = in_data+STEP.
    - Mismatch: push with err=1, increment err_count, and resync expected = in_data+STEP. The state stays LOCKED; only rst returns the FSM to UNLOCKED.
- Arithmetic: expected wraps modulo 2^WIDTH, so 0xFF followed by 0x00 is a match with STEP=1. Counters saturate at all-ones and do not wrap.
- FIFO:
  - An entry is {err, data}.
  - Push happens when in_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Pop happens when out_valid && out_ready.
  - Simultaneous push and pop is legal at any occupancy, including empty. On empty the pushed word becomes visible the next cycle (no fall-through).
- Latency: a sample accepted in cycle N appears on out_data/out_valid in cycle N+1 if the FIFO was empty.
- Full with no pop:
  - The sample is dropped, drop_count increments, and overflow is set.
  - The checker still evaluates the dropped sample and updates expected and err_count, so sequence tracking stays exact.
- Empty with out_ready=1: no effect. out_valid stays 0 and the pointers do not move.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_err hold stable.
- locked=1 from the cycle after the first accepted sample until rst.

Decomposition:
- Package seq_cap_pkg:
  - state enum: UNLOCKED, LOCKED.
  - entry struct: err bit plus data.
  - default constants for WIDTH, DEPTH, STEP, CNT_W.
  - saturating-increment function.
- One sub-module, sync_fifo, parameterised on entry width and DEPTH. It uses pointer-plus-wrap-bit full/empty detection and reports push_ok.
- The checker FSM and counters stay in the top module.

Test Plan:
- Reset then 0x05,0x06,0x07 on consecutive cycles with out_ready=1 -> out_data 0x05,0x06,0x07 with out_err=0; err_count=0; locked=1 after first cycle.
- Wrap: 0xFE,0xFF,0x00,0x01 -> all out_err=0; err_count=0.
- Break: 0x10,0x11,0x15,0x16 -> 0x15 carries out_err=1, 0x16 out_err=0 (resync); err_count=1.
- Overflow: out_ready=0, 10 consecutive samples 0x00..0x09 with DEPTH=8 -> 8 entries held, drop_count=2, overflow=1. Then out_ready=1 drains 0x00..0x07 in order; a following 0x0A gives out_err=0 (tracking kept through the drops).
- Full with simultaneous push/pop: FIFO full, out_ready=1 and in_valid=1 same cycle -> no drop, occupancy stays 8, drop_count unchanged.
- Reset mid-stream: 3 entries buffered, assert rst for one cycle -> next cycle out_valid=0, locked=0, counters 0. Next sample 0x40 is accepted with out_err=0 regardless of its value.

Source files
------------

// File: rtl/seq_cap_pkg.sv
// Shared types, default parameters and helpers for the sequence capture checker.
package seq_cap_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefStep  = 1;
  localparam int unsigned DefCntW  = 16;

  // Checker state: waiting for a first reference sample, or tracking the sequence.
  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } state_e;

  // Buffered entry at the default width: sequence-break flag plus sample value.
  typedef struct packed {
    logic                err;
    logic [DefWidth-1:0] data;
  } entry_t;

  // Increment val, holding at all-ones of the given width instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] lim;
    lim = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (val >= lim) ? lim : val + 64'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push on a full FIFO is accepted
// only when a pop frees the head slot in the same cycle. No fall-through.
module sync_fifo #(
  parameter int unsigned ENTRY_W = 9,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               empty,
  output logic               full,
  output logic               push_ok
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               pop_ok;

  // Occupancy flags and handshake qualification.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    rdata   = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer update; reset drops every buffered entry at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; on full push+pop the write slot is the head being read this cycle.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/seq_capture_checker.sv
// Checks that sampled values advance by STEP, tags each with an error flag and
// buffers the tagged samples for a valid/ready consumer.
module seq_capture_checker
  import seq_cap_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned STEP  = DefStep,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } entry_w_t;

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic             sample_err;

  entry_w_t push_entry, head_entry;
  logic     fifo_empty, fifo_full, push_ok;

  sync_fifo #(
    .ENTRY_W ($bits(entry_w_t)),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .pop     (out_ready),
    .wdata   (push_entry),
    .rdata   (head_entry),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .push_ok (push_ok)
  );

  // Sequence check and statistics; dropped samples still advance the tracking.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    sample_err = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StUnlocked: begin
          state_d = StLocked;
        end
        StLocked: begin
          sample_err = (in_data != exp_q);
          if (sample_err) err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), CNT_W));
        end
        default: state_d = StUnlocked;
      endcase
      exp_d = in_data + StepW;
      if (!push_ok) begin
        drop_cnt_d = CNT_W'(sat_inc(64'(drop_cnt_q), CNT_W));
        ovf_d      = 1'b1;
      end
    end
    push_entry = '{err: sample_err, data: in_data};
  end

  // Checker state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StUnlocked;
      exp_q      <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Head presentation; value forced to zero while nothing is buffered.
  always_comb begin
    out_valid  = !fifo_empty;
    out_data   = out_valid ? head_entry.data : '0;
    out_err    = out_valid ? head_entry.err : 1'b0;
    locked     = (state_q == StLocked);
    err_count  = err_cnt_q;
    drop_count = drop_cnt_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_seq_capture_checker.sv
// Scenario bench for seq_capture_checker with a queue scoreboard of tagged samples.
module tb_seq_capture_checker;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       locked;
  logic [15:0] err_count;
  logic [15:0] drop_count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [8:0]  sb_q[$];
  logic        m_locked;
  logic [7:0]  m_exp;
  logic [15:0] m_err_cnt;
  logic [15:0] m_drop_cnt;
  logic        m_ovf;

  seq_capture_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .locked     (locked),
    .err_count  (err_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs just after a negedge, check head against the scoreboard,
  // update the model for the coming posedge, then wait for the next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic [8:0] head;
    logic       pop;
    logic       e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    n_cmp++;
    if (out_valid !== (sb_q.size() != 0)) begin
      n_bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, sb_q.size() != 0);
    end
    pop = r && (sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      n_cmp++;
      if ({out_err, out_data} !== head) begin
        n_bad++;
        $display("FAIL head: got err=%b data=%h want err=%b data=%h",
                 out_err, out_data, head[8], head[7:0]);
      end
      if (pop) void'(sb_q.pop_front());
    end
    if (v) begin
      e = m_locked && (d != m_exp);
      if (e && m_err_cnt != 16'hFFFF) m_err_cnt++;
      m_exp    = d + 8'd1;
      m_locked = 1'b1;
      if (sb_q.size() < Depth) sb_q.push_back({e, d});
      else begin
        if (m_drop_cnt != 16'hFFFF) m_drop_cnt++;
        m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    sb_q.delete();
    m_locked   = 1'b0;
    m_exp      = '0;
    m_err_cnt  = '0;
    m_drop_cnt = '0;
    m_ovf      = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, locked, out_data, out_err} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b locked=%b data=%h err=%b want all 0",
               out_valid, locked, out_data, out_err);
    end
    n_cmp++;
    if ({err_count, drop_count, overflow} !== 33'b0) begin
      n_bad++;
      $display("FAIL reset_status: got err=%0d drop=%0d ovf=%b want 0", err_count,
               drop_count, overflow);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 8'h05, 1'b1);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_locked: got %b want 1", locked);
    end
    step(1'b1, 8'h06, 1'b1);
    step(1'b1, 8'h07, 1'b1);
    drain(2);
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL basic_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] vals[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    foreach (vals[i]) step(1'b1, vals[i], 1'b1);
    drain(2);
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL wrap_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_break();
    logic [7:0] vals[4] = '{8'h10, 8'h11, 8'h15, 8'h16};
    do_reset();
    foreach (vals[i]) step(1'b1, vals[i], 1'b1);
    drain(2);
    n_cmp++;
    if (err_count !== 16'd1) begin
      n_bad++;
      $display("FAIL break_err_count: got %0d want 1", err_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
    n_cmp++;
    if (drop_count !== 16'd2 || overflow !== 1'b1 || m_drop_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL ovf_status: got drop=%0d ovf=%b want drop=2 ovf=1", drop_count, overflow);
    end
    drain(8);
    step(1'b1, 8'h0A, 1'b1);
    drain(1);
    n_cmp++;
    if (err_count !== 16'd0 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_tracking: got err=%0d ovf=%b want err=0 ovf=1", err_count, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    step(1'b1, 8'h28, 1'b1);
    n_cmp++;
    if (drop_count !== 16'd0) begin
      n_bad++;
      $display("FAIL fullpp_no_drop: got %0d want 0", drop_count);
    end
    // Still full afterwards: one more push without pop must drop.
    step(1'b1, 8'h29, 1'b0);
    n_cmp++;
    if (drop_count !== 16'd1 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL fullpp_occupancy: got drop=%0d ovf=%b want drop=1 ovf=1",
               drop_count, overflow);
    end
    drain(9);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 8'h30, 1'b0);
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h39, 1'b0);
    do_reset();
    n_cmp++;
    if ({out_valid, locked, err_count, drop_count, overflow} !== 35'b0) begin
      n_bad++;
      $display("FAIL midrst_state: got valid=%b locked=%b err=%0d drop=%0d ovf=%b want 0",
               out_valid, locked, err_count, drop_count, overflow);
    end
    step(1'b1, 8'h40, 1'b1);
    drain(2);
    n_cmp++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst_relock: got locked=%b err=%0d want locked=1 err=0", locked,
               err_count);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_break();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
